// File: rtl/trig_capture.sv
// trig_capture: triggered sample capture into a circular buffer with pre/post-trigger frame readout.
module trig_capture #(
  parameter int DWL = 8,
  parameter int AW  = 10,
  parameter int HW  = 16
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  input  logic [DWL-1:0] I_DIN,
  input  logic           I_DEN,
  input  logic [1:0]     I_T_MODE,
  input  logic [DWL-1:0] I_TRIG_V_MAX,
  input  logic [DWL-1:0] I_TRIG_V_MIN,
  input  logic [AW-1:0]  I_PRE_LEN,
  input  logic [AW-1:0]  I_POST_LEN,
  input  logic [HW-1:0]  I_HOLDOFF,
  input  logic           I_SINGLE,
  input  logic           I_ARM,
  input  logic           I_RD_EN,
  output logic [DWL-1:0] O_DOUT,
  output logic           O_DOV,
  output logic           O_RD_LAST,
  output logic           O_TRIG_ON,
  output logic           O_READY,
  output logic [2:0]     O_STATE
);
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, WAIT = 3'd2, POST = 3'd3, READY = 3'd4, HOLD = 3'd5} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  state_t st, nxt;
  logic [DWL-1:0] mem [0:(1<<AW)-1];
  logic [1:0] mode;
  logic [DWL-1:0] vmax, vmin, prev;
  logic prev_v, single;
  logic [AW-1:0] pre, post, wp, taddr, cnt, post_c, raddr;
  logic [HW-1:0] holdoff, hcnt;
  logic [AW:0] ridx, flen, sum;
  logic in_range, hit, wr, trig, rd_go, last;
  // PRE cannot exceed DEPTH-1 at this port width, so only POST needs clamping
  assign sum = {1'b0, I_PRE_LEN} + {1'b0, I_POST_LEN} + (AW+1)'(1);
  assign post_c = (sum > DEPTH) ? ~I_PRE_LEN : I_POST_LEN;
  assign flen = {1'b0, pre} + {1'b0, post} + (AW+1)'(1);
  assign raddr = taddr - pre + ridx[AW-1:0];
  assign in_range = I_DIN >= vmin && I_DIN <= vmax;
  assign hit = mode == 2'd0 ? 1'b1 :
               mode == 2'd1 ? prev_v && I_DIN > prev && in_range :
               mode == 2'd2 ? prev_v && I_DIN < prev && in_range : in_range;
  assign wr = I_DEN && !I_ARM && (st == FILL || st == WAIT || st == POST);
  assign trig = wr && st == WAIT && hit;
  assign rd_go = I_RD_EN && !I_ARM && st == READY;
  assign last = ridx == flen - (AW+1)'(1);
  assign O_READY = st == READY;
  assign O_STATE = st;
  always_ff @(posedge I_CLK or posedge I_RST)
    if (I_RST) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    if (I_ARM) nxt = FILL;
    else
      case (st)
        FILL:    if (pre == '0 || (wr && cnt == pre - AW'(1))) nxt = WAIT;
        WAIT:    if (trig) nxt = post == '0 ? READY : POST;
        POST:    if (wr && cnt == post - AW'(1)) nxt = READY;
        READY:   if (rd_go && last) nxt = single ? IDLE : HOLD;
        HOLD:    if ({1'b0, hcnt} + (HW+1)'(1) >= {1'b0, holdoff}) nxt = FILL;
        default: nxt = st;
      endcase
  end
  always_ff @(posedge I_CLK)
    if (wr) mem[wp] <= I_DIN;
  always_ff @(posedge I_CLK or posedge I_RST)
    if (I_RST) begin
      O_DOUT <= '0;
      O_DOV <= 1'b0;
      O_RD_LAST <= 1'b0;
      O_TRIG_ON <= 1'b0;
      mode <= '0;
      vmax <= '0;
      vmin <= '0;
      pre <= '0;
      post <= '0;
      holdoff <= '0;
      single <= 1'b0;
      wp <= '0;
      taddr <= '0;
      cnt <= '0;
      hcnt <= '0;
      ridx <= '0;
      prev <= '0;
      prev_v <= 1'b0;
    end else begin
      O_TRIG_ON <= trig;
      O_DOV <= rd_go;
      O_RD_LAST <= rd_go && last;
      if (rd_go) O_DOUT <= mem[raddr];
      if (I_ARM) begin
        mode <= I_T_MODE;
        vmax <= I_TRIG_V_MAX;
        vmin <= I_TRIG_V_MIN;
        pre <= I_PRE_LEN;
        post <= post_c;
        holdoff <= I_HOLDOFF;
        single <= I_SINGLE;
        wp <= '0;
        cnt <= '0;
        hcnt <= '0;
        ridx <= '0;
        prev_v <= 1'b0;
      end else begin
        if (wr) begin
          wp <= wp + AW'(1);
          prev <= I_DIN;
          prev_v <= 1'b1;
        end
        if (st == HOLD && nxt == FILL) prev_v <= 1'b0;
        if (trig) taddr <= wp;
        // every state change restarts the per-state counters
        cnt <= nxt != st ? '0 : wr ? cnt + AW'(1) : cnt;
        hcnt <= nxt != st ? '0 : hcnt + HW'(1);
        ridx <= st != READY ? '0 : rd_go ? ridx + (AW+1)'(1) : ridx;
      end
    end
endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture: scoreboard bench for trig_capture with DWL=8, AW=4.
module tb_trig_capture;
  logic I_CLK = 1'b0;
  logic I_RST, I_DEN, I_SINGLE, I_ARM, I_RD_EN;
  logic [7:0] I_DIN, I_TRIG_V_MAX, I_TRIG_V_MIN, O_DOUT;
  logic [1:0] I_T_MODE;
  logic [3:0] I_PRE_LEN, I_POST_LEN;
  logic [15:0] I_HOLDOFF;
  logic O_DOV, O_RD_LAST, O_TRIG_ON, O_READY;
  logic [2:0] O_STATE;
  int n_chk = 0, n_fail = 0;
  logic [8:0] sb[$];
  logic seen;

  trig_capture #(.DWL(8), .AW(4), .HW(16)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_DIN(I_DIN), .I_DEN(I_DEN), .I_T_MODE(I_T_MODE),
    .I_TRIG_V_MAX(I_TRIG_V_MAX), .I_TRIG_V_MIN(I_TRIG_V_MIN), .I_PRE_LEN(I_PRE_LEN),
    .I_POST_LEN(I_POST_LEN), .I_HOLDOFF(I_HOLDOFF), .I_SINGLE(I_SINGLE), .I_ARM(I_ARM),
    .I_RD_EN(I_RD_EN), .O_DOUT(O_DOUT), .O_DOV(O_DOV), .O_RD_LAST(O_RD_LAST),
    .O_TRIG_ON(O_TRIG_ON), .O_READY(O_READY), .O_STATE(O_STATE)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge I_CLK);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] mn, input logic [7:0] mx,
                     input logic [3:0] pre, input logic [3:0] post, input logic [15:0] ho, input logic sgl);
    I_T_MODE = m;
    I_TRIG_V_MIN = mn;
    I_TRIG_V_MAX = mx;
    I_PRE_LEN = pre;
    I_POST_LEN = post;
    I_HOLDOFF = ho;
    I_SINGLE = sgl;
    I_ARM = 1'b1;
    tick;
    I_ARM = 1'b0;
    chk("arm_fill", O_STATE, 1);
  endtask

  task automatic samp(input logic [7:0] v);
    I_DIN = v;
    I_DEN = 1'b1;
    tick;
    I_DEN = 1'b0;
  endtask

  task automatic rd(input logic [7:0] v, input logic l);
    I_RD_EN = 1'b1;
    sb.push_back({l, v});
    tick;
    I_RD_EN = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 4 && sb.size() > 0; i++) tick;
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge I_CLK)
    if (O_DOV) begin
      chk("dov_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("dout", O_DOUT, e[7:0]);
        chk("rd_last", O_RD_LAST, e[8]);
      end
    end else chk("rd_last_idle", O_RD_LAST, 0);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    {I_DEN, I_SINGLE, I_ARM, I_RD_EN, I_DIN, I_TRIG_V_MAX, I_TRIG_V_MIN, I_T_MODE} = '0;
    {I_PRE_LEN, I_POST_LEN, I_HOLDOFF} = '0;
    I_RST = 1'b0;
    #2 I_RST = 1'b1;
    tick;
    tick;
    chk("rst_state", O_STATE, 0);
    chk("rst_outs", {O_DOUT, O_DOV, O_RD_LAST, O_TRIG_ON, O_READY}, 0);
    I_RST = 1'b0;
    I_RD_EN = 1'b1;
    tick;
    tick;
    I_RD_EN = 1'b0;
    chk("idle_rd_dov", O_DOV, 0);
    // rising edge into range, ramp 0x00 step 0x10
    cfg(2'b01, 8'h40, 8'h80, 4'd3, 4'd4, 16'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      samp(8'(i * 16));
      chk("a_trig", O_TRIG_ON, i == 4);
    end
    chk("a_ready", O_READY, 1);
    chk("a_state", O_STATE, 4);
    for (int j = 0; j < 8; j++) rd(8'((j + 1) * 16), j == 7);
    drain;
    chk("a_idle", O_STATE, 0);
    chk("a_ready_low", O_READY, 0);
    // falling edge with a flat input never triggers
    cfg(2'b10, 8'h40, 8'h80, 4'd2, 4'd2, 16'd0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      samp(8'h50);
      seen |= O_TRIG_ON;
    end
    chk("b_notrig", seen, 0);
    chk("b_wait", O_STATE, 2);
    // POST clamps to 5, full 16-sample frame
    cfg(2'b00, 8'h00, 8'hff, 4'd10, 4'd10, 16'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      samp(8'(i + 1));
      chk("c_trig", O_TRIG_ON, i == 10);
    end
    chk("c_ready", O_READY, 1);
    for (int j = 0; j < 16; j++) rd(8'(j + 1), j == 15);
    drain;
    chk("c_idle", O_STATE, 0);
    // auto re-arm with holdoff 5
    cfg(2'b11, 8'h40, 8'h80, 4'd1, 4'd1, 16'd5, 1'b0);
    samp(8'h10);
    chk("d_trig0", O_TRIG_ON, 0);
    samp(8'h20);
    chk("d_trig1", O_TRIG_ON, 0);
    samp(8'h50);
    chk("d_trig2", O_TRIG_ON, 1);
    samp(8'h60);
    chk("d_ready", O_READY, 1);
    rd(8'h20, 1'b0);
    rd(8'h50, 1'b0);
    rd(8'h60, 1'b1);
    I_DIN = 8'h55;
    I_DEN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("d_hold", O_STATE, 5);
      chk("d_hold_trig", O_TRIG_ON, 0);
      tick;
    end
    I_DEN = 1'b0;
    chk("d_fill", O_STATE, 1);
    chk("d_fill_trig", O_TRIG_ON, 0);
    samp(8'h30);
    chk("d2_trig0", O_TRIG_ON, 0);
    samp(8'h45);
    chk("d2_trig1", O_TRIG_ON, 1);
    samp(8'h47);
    chk("d2_ready", O_READY, 1);
    rd(8'h30, 1'b0);
    rd(8'h45, 1'b0);
    rd(8'h47, 1'b1);
    drain;
    chk("d2_hold", O_STATE, 5);
    // arm during readout wins over a concurrent read
    cfg(2'b00, 8'h00, 8'hff, 4'd1, 4'd2, 16'd0, 1'b1);
    samp(8'h11);
    samp(8'h22);
    chk("e_trig", O_TRIG_ON, 1);
    samp(8'h33);
    samp(8'h44);
    chk("e_ready", O_READY, 1);
    rd(8'h11, 1'b0);
    rd(8'h22, 1'b0);
    I_ARM = 1'b1;
    I_RD_EN = 1'b1;
    tick;
    I_ARM = 1'b0;
    I_RD_EN = 1'b0;
    chk("e_ready_low", O_READY, 0);
    chk("e_fill", O_STATE, 1);
    chk("e_nodov", O_DOV, 0);
    drain;
    // reset mid-capture
    cfg(2'b00, 8'h00, 8'hff, 4'd1, 4'd3, 16'd0, 1'b1);
    samp(8'h01);
    samp(8'h02);
    chk("f_trig", O_TRIG_ON, 1);
    chk("f_post", O_STATE, 3);
    I_RST = 1'b1;
    #1;
    chk("f_rst_state", O_STATE, 0);
    chk("f_rst_outs", {O_DOUT, O_DOV, O_RD_LAST, O_TRIG_ON, O_READY}, 0);
    tick;
    I_RST = 1'b0;
    I_RD_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("f_nodov", O_DOV, 0);
    end
    I_RD_EN = 1'b0;
    chk("f_idle", O_STATE, 0);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
